// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller: register
// addresses and hazard qualifiers in, stage enables/clears and forwarding selects out.
interface pipe_hazard_ctrl_if #(
    parameter int RW = 5,
    parameter int CW = 16
);
    logic [RW-1:0] i_rsD, i_rtD, i_rsE, i_rtE;
    logic [RW-1:0] i_writeregE, i_writeregM, i_writeregW;
    logic          i_regwriteE, i_regwriteM, i_regwriteW;
    logic          i_memtoregE, i_memtoregM;
    logic          i_branchD;
    logic          i_mdstartE;
    logic          i_memreqM;
    logic          i_ready;

    logic          o_StallF, o_StallD, o_StallE, o_StallM;
    logic          o_FlushE, o_FlushM, o_FlushW;
    logic          o_ForwardAD, o_ForwardBD;
    logic [1:0]    o_ForwardAE, o_ForwardBE;
    logic          o_mdbusy;
    logic [CW-1:0] o_stallcnt;

    modport master (
        output i_rsD, i_rtD, i_rsE, i_rtE,
        output i_writeregE, i_writeregM, i_writeregW,
        output i_regwriteE, i_regwriteM, i_regwriteW,
        output i_memtoregE, i_memtoregM, i_branchD,
        output i_mdstartE, i_memreqM, i_ready,
        input  o_StallF, o_StallD, o_StallE, o_StallM,
        input  o_FlushE, o_FlushM, o_FlushW,
        input  o_ForwardAD, o_ForwardBD, o_ForwardAE, o_ForwardBE,
        input  o_mdbusy, o_stallcnt
    );

    modport slave (
        input  i_rsD, i_rtD, i_rsE, i_rtE,
        input  i_writeregE, i_writeregM, i_writeregW,
        input  i_regwriteE, i_regwriteM, i_regwriteW,
        input  i_memtoregE, i_memtoregM, i_branchD,
        input  i_mdstartE, i_memreqM, i_ready,
        output o_StallF, o_StallD, o_StallE, o_StallM,
        output o_FlushE, o_FlushM, o_FlushW,
        output o_ForwardAD, o_ForwardBD, o_ForwardAE, o_ForwardBE,
        output o_mdbusy, o_stallcnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and stall controller for the 5-stage F/D/E/M/W pipeline,
// with memory-ready freeze, multi-cycle execute tracking and a saturating stall counter.
module pipe_hazard_ctrl #(
    parameter int RW     = 5,
    parameter int MD_LAT = 4,
    parameter int CW     = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    pipe_hazard_ctrl_if.slave bus
);
    typedef enum logic {RUN, MDWAIT} state_t;

    localparam bit         MD_MULTI = (MD_LAT > 1);
    localparam logic [3:0] CNT_INIT = MD_MULTI ? 4'(MD_LAT - 2) : 4'd0;

    state_t        r_state;
    logic [3:0]    r_cnt;
    logic [CW-1:0] r_stallcnt;

    logic       w_lwstall, w_brstall, w_memstall, w_mdstall;
    logic       w_srcHitE, w_srcHitM;
    logic       w_stallF, w_stallD, w_stallE, w_stallM;
    logic       w_flushE, w_flushM, w_flushW;
    logic [1:0] w_fwdAE, w_fwdBE;
    logic       w_fwdAD, w_fwdBD;

    // Register 0 is hardwired to zero, so it never creates a dependency.
    function automatic logic regMatch(input logic [RW-1:0] a, input logic [RW-1:0] b);
        return (a != '0) && (a == b);
    endfunction

    function automatic logic [1:0] fwdSelE(input logic [RW-1:0] src);
        if (bus.i_regwriteM && regMatch(bus.i_writeregM, src))
            return 2'b10;
        else if (bus.i_regwriteW && regMatch(bus.i_writeregW, src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        w_fwdAE = fwdSelE(bus.i_rsE);
        w_fwdBE = fwdSelE(bus.i_rtE);
        w_fwdAD = bus.i_regwriteM && regMatch(bus.i_writeregM, bus.i_rsD);
        w_fwdBD = bus.i_regwriteM && regMatch(bus.i_writeregM, bus.i_rtD);
    end

    always_comb begin
        w_srcHitE  = regMatch(bus.i_writeregE, bus.i_rsD) || regMatch(bus.i_writeregE, bus.i_rtD);
        w_srcHitM  = regMatch(bus.i_writeregM, bus.i_rsD) || regMatch(bus.i_writeregM, bus.i_rtD);
        w_lwstall  = bus.i_memtoregE && w_srcHitE;
        w_brstall  = bus.i_branchD &&
                     ((bus.i_regwriteE && w_srcHitE) || (bus.i_memtoregM && w_srcHitM));
        w_memstall = bus.i_memreqM && !bus.i_ready;
    end

    // A new op only raises mdstall in RUN; in MDWAIT it stays high until the countdown empties.
    always_comb begin
        w_mdstall = 1'b0;
        case (r_state)
            RUN:     w_mdstall = bus.i_mdstartE && MD_MULTI;
            MDWAIT:  w_mdstall = (r_cnt != 4'd0);
            default: w_mdstall = 1'b0;
        endcase
    end

    always_comb begin
        w_stallF = 1'b0;
        w_stallD = 1'b0;
        w_stallE = 1'b0;
        w_stallM = 1'b0;
        w_flushE = 1'b0;
        w_flushM = 1'b0;
        w_flushW = 1'b0;
        if (w_memstall) begin
            w_stallF = 1'b1;
            w_stallD = 1'b1;
            w_stallE = 1'b1;
            w_stallM = 1'b1;
            w_flushW = 1'b1;
        end else if (w_mdstall) begin
            w_stallF = 1'b1;
            w_stallD = 1'b1;
            w_stallE = 1'b1;
            w_flushM = 1'b1;
        end else if (w_lwstall || w_brstall) begin
            w_stallF = 1'b1;
            w_stallD = 1'b1;
            w_flushE = 1'b1;
        end
    end

    // The mul/div unit keeps counting through a memory freeze; only the exit to RUN waits for it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= RUN;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                RUN: begin
                    if (bus.i_mdstartE && MD_MULTI) begin
                        r_state <= MDWAIT;
                        r_cnt   <= CNT_INIT;
                    end
                end
                MDWAIT: begin
                    if (r_cnt != 4'd0)
                        r_cnt <= r_cnt - 4'd1;
                    else if (!w_memstall)
                        r_state <= RUN;
                end
                default: begin
                    r_state <= RUN;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_stallcnt <= '0;
        else if (w_stallF && (r_stallcnt != '1))
            r_stallcnt <= r_stallcnt + CW'(1);
    end

    assign bus.o_StallF    = w_stallF;
    assign bus.o_StallD    = w_stallD;
    assign bus.o_StallE    = w_stallE;
    assign bus.o_StallM    = w_stallM;
    assign bus.o_FlushE    = w_flushE;
    assign bus.o_FlushM    = w_flushM;
    assign bus.o_FlushW    = w_flushW;
    assign bus.o_ForwardAE = w_fwdAE;
    assign bus.o_ForwardBE = w_fwdBE;
    assign bus.o_ForwardAD = w_fwdAD;
    assign bus.o_ForwardBD = w_fwdBD;
    assign bus.o_mdbusy    = (r_state == MDWAIT);
    assign bus.o_stallcnt  = r_stallcnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Two controllers (MD_LAT=4/CW=16 and MD_LAT=3/CW=2) share one stimulus stream
// and are compared each cycle against a cycle-age behavioural model.
module tb_pipe_hazard_ctrl;
    localparam int RW    = 5;
    localparam int LAT_A = 4;
    localparam int CW_A  = 16;
    localparam int LAT_B = 3;
    localparam int CW_B  = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.RW(RW), .CW(CW_A)) ifA();
    pipe_hazard_ctrl_if #(.RW(RW), .CW(CW_B)) ifB();

    pipe_hazard_ctrl #(.RW(RW), .MD_LAT(LAT_A), .CW(CW_A)) u_dutA (
        .i_clk(clk), .i_rst_n(rst_n), .bus(ifA.slave));
    pipe_hazard_ctrl #(.RW(RW), .MD_LAT(LAT_B), .CW(CW_B)) u_dutB (
        .i_clk(clk), .i_rst_n(rst_n), .bus(ifB.slave));

    typedef struct {
        logic [RW-1:0] rsD, rtD, rsE, rtE, wE, wM, wW;
        logic rwE, rwM, rwW, mtrE, mtrM, branchD, mdstartE, memreqM, ready;
    } stim_t;

    typedef struct {
        logic [3:0]  stall;
        logic [2:0]  flush;
        logic [1:0]  fwdD;
        logic [1:0]  fwdAE, fwdBE;
        logic        mdbusy;
        logic [15:0] stallcnt;
    } outs_t;

    int    checks = 0;
    int    errors = 0;
    int    mdLat[2]  = '{LAT_A, LAT_B};
    int    cntMax[2] = '{(1 << CW_A) - 1, (1 << CW_B) - 1};
    string nm[2]     = '{"A", "B"};
    bit    mdActive[2];
    int    mdAge[2];
    int    stallCount[2];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit hit(input logic [RW-1:0] a, input logic [RW-1:0] b);
        return (a != '0) && (a == b);
    endfunction

    function automatic stim_t zeroStim();
        stim_t s;
        s.rsD = '0; s.rtD = '0; s.rsE = '0; s.rtE = '0;
        s.wE = '0; s.wM = '0; s.wW = '0;
        s.rwE = 0; s.rwM = 0; s.rwW = 0; s.mtrE = 0; s.mtrM = 0;
        s.branchD = 0; s.mdstartE = 0; s.memreqM = 0; s.ready = 0;
        return s;
    endfunction

    function automatic stim_t randStim();
        stim_t s;
        s.rsD = RW'($urandom_range(0, 4)); s.rtD = RW'($urandom_range(0, 4));
        s.rsE = RW'($urandom_range(0, 4)); s.rtE = RW'($urandom_range(0, 4));
        s.wE  = RW'($urandom_range(0, 4)); s.wM  = RW'($urandom_range(0, 4));
        s.wW  = RW'($urandom_range(0, 4));
        s.rwE = 1'($urandom_range(0, 1)); s.rwM = 1'($urandom_range(0, 1));
        s.rwW = 1'($urandom_range(0, 1));
        s.mtrE = ($urandom_range(0, 3) == 0); s.mtrM = ($urandom_range(0, 3) == 0);
        s.branchD  = ($urandom_range(0, 3) == 0);
        s.mdstartE = ($urandom_range(0, 7) == 0);
        s.memreqM  = 1'($urandom_range(0, 1));
        s.ready    = ($urandom_range(0, 3) != 0);
        return s;
    endfunction

    // Model: mul/div op is tracked by its age in cycles since it entered E.
    function automatic outs_t modelOutputs(input int k, input stim_t s);
        outs_t o;
        bit memS = s.memreqM && !s.ready;
        bit mdS  = mdActive[k] ? (mdAge[k] < mdLat[k] - 1) : (s.mdstartE && mdLat[k] > 1);
        bit lw   = s.mtrE && (hit(s.wE, s.rsD) || hit(s.wE, s.rtD));
        bit br   = s.branchD && ((s.rwE && (hit(s.wE, s.rsD) || hit(s.wE, s.rtD))) ||
                                 (s.mtrM && (hit(s.wM, s.rsD) || hit(s.wM, s.rtD))));
        o.stall = 4'b0000;
        o.flush = 3'b000;
        if (memS) begin
            o.stall = 4'b1111; o.flush = 3'b001;
        end else if (mdS) begin
            o.stall = 4'b1110; o.flush = 3'b010;
        end else if (lw || br) begin
            o.stall = 4'b1100; o.flush = 3'b100;
        end
        o.fwdAE = (s.rwM && hit(s.wM, s.rsE)) ? 2'b10 : (s.rwW && hit(s.wW, s.rsE)) ? 2'b01 : 2'b00;
        o.fwdBE = (s.rwM && hit(s.wM, s.rtE)) ? 2'b10 : (s.rwW && hit(s.wW, s.rtE)) ? 2'b01 : 2'b00;
        o.fwdD     = {s.rwM && hit(s.wM, s.rsD), s.rwM && hit(s.wM, s.rtD)};
        o.mdbusy   = mdActive[k];
        o.stallcnt = 16'(stallCount[k]);
        return o;
    endfunction

    task automatic modelAdvance(input int k, input stim_t s, input outs_t e);
        bit memS = s.memreqM && !s.ready;
        if (e.stall[3] && stallCount[k] < cntMax[k])
            stallCount[k]++;
        if (mdActive[k]) begin
            if (mdAge[k] >= mdLat[k] - 1 && !memS)
                mdActive[k] = 0;
            else
                mdAge[k]++;
        end else if (s.mdstartE && mdLat[k] > 1) begin
            mdActive[k] = 1;
            mdAge[k]    = 1;
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            mdActive[k] = 0; mdAge[k] = 0; stallCount[k] = 0;
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        ifA.i_rsD = s.rsD; ifA.i_rtD = s.rtD; ifA.i_rsE = s.rsE; ifA.i_rtE = s.rtE;
        ifA.i_writeregE = s.wE; ifA.i_writeregM = s.wM; ifA.i_writeregW = s.wW;
        ifA.i_regwriteE = s.rwE; ifA.i_regwriteM = s.rwM; ifA.i_regwriteW = s.rwW;
        ifA.i_memtoregE = s.mtrE; ifA.i_memtoregM = s.mtrM; ifA.i_branchD = s.branchD;
        ifA.i_mdstartE = s.mdstartE; ifA.i_memreqM = s.memreqM; ifA.i_ready = s.ready;
        ifB.i_rsD = s.rsD; ifB.i_rtD = s.rtD; ifB.i_rsE = s.rsE; ifB.i_rtE = s.rtE;
        ifB.i_writeregE = s.wE; ifB.i_writeregM = s.wM; ifB.i_writeregW = s.wW;
        ifB.i_regwriteE = s.rwE; ifB.i_regwriteM = s.rwM; ifB.i_regwriteW = s.rwW;
        ifB.i_memtoregE = s.mtrE; ifB.i_memtoregM = s.mtrM; ifB.i_branchD = s.branchD;
        ifB.i_mdstartE = s.mdstartE; ifB.i_memreqM = s.memreqM; ifB.i_ready = s.ready;
    endtask

    task automatic runCycle(input stim_t s);
        outs_t o[2];
        outs_t e[2];
        @(negedge clk);
        applyStimulus(s);
        #1;
        o[0].stall = {ifA.o_StallF, ifA.o_StallD, ifA.o_StallE, ifA.o_StallM};
        o[0].flush = {ifA.o_FlushE, ifA.o_FlushM, ifA.o_FlushW};
        o[0].fwdD  = {ifA.o_ForwardAD, ifA.o_ForwardBD};
        o[0].fwdAE = ifA.o_ForwardAE; o[0].fwdBE = ifA.o_ForwardBE;
        o[0].mdbusy = ifA.o_mdbusy; o[0].stallcnt = 16'(ifA.o_stallcnt);
        o[1].stall = {ifB.o_StallF, ifB.o_StallD, ifB.o_StallE, ifB.o_StallM};
        o[1].flush = {ifB.o_FlushE, ifB.o_FlushM, ifB.o_FlushW};
        o[1].fwdD  = {ifB.o_ForwardAD, ifB.o_ForwardBD};
        o[1].fwdAE = ifB.o_ForwardAE; o[1].fwdBE = ifB.o_ForwardBE;
        o[1].mdbusy = ifB.o_mdbusy; o[1].stallcnt = 16'(ifB.o_stallcnt);
        for (int k = 0; k < 2; k++) begin
            e[k] = modelOutputs(k, s);
            checkOutput({nm[k], ".stall"},    32'(o[k].stall),    32'(e[k].stall));
            checkOutput({nm[k], ".flush"},    32'(o[k].flush),    32'(e[k].flush));
            checkOutput({nm[k], ".fwdD"},     32'(o[k].fwdD),     32'(e[k].fwdD));
            checkOutput({nm[k], ".fwdAE"},    32'(o[k].fwdAE),    32'(e[k].fwdAE));
            checkOutput({nm[k], ".fwdBE"},    32'(o[k].fwdBE),    32'(e[k].fwdBE));
            checkOutput({nm[k], ".mdbusy"},   32'(o[k].mdbusy),   32'(e[k].mdbusy));
            checkOutput({nm[k], ".stallcnt"}, 32'(o[k].stallcnt), 32'(e[k].stallcnt));
        end
        for (int k = 0; k < 2; k++)
            modelAdvance(k, s, e[k]);
    endtask

    // Pulse reset between edges; state must clear without waiting for a clock.
    task automatic doReset();
        rst_n = 1'b0;
        #1;
        checkOutput("rst.A.mdbusy",   32'(ifA.o_mdbusy),   32'd0);
        checkOutput("rst.A.stallcnt", 32'(ifA.o_stallcnt), 32'd0);
        checkOutput("rst.B.mdbusy",   32'(ifB.o_mdbusy),   32'd0);
        checkOutput("rst.B.stallcnt", 32'(ifB.o_stallcnt), 32'd0);
        modelReset();
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        stim_t z;
        stim_t s;
        int    base;
        z = zeroStim();
        modelReset();
        rst_n = 1'b0;
        applyStimulus(z);
        runCycle(z);
        runCycle(z);
        rst_n = 1'b1;
        runCycle(z);

        s = z; s.rsE = 3; s.wM = 3; s.rwM = 1; s.wW = 3; s.rwW = 1;
        runCycle(s);
        checkOutput("fwdAE_M", 32'(ifA.o_ForwardAE), 32'b10);
        s.rwM = 0;
        runCycle(s);
        checkOutput("fwdAE_W", 32'(ifA.o_ForwardAE), 32'b01);
        s.rsE = 0;
        runCycle(s);
        checkOutput("fwdAE_r0", 32'(ifA.o_ForwardAE), 32'b00);

        s = z; s.mtrE = 1; s.rwE = 1; s.wE = 5; s.rtD = 5;
        runCycle(s);
        checkOutput("lw_stall", 32'({ifA.o_StallF, ifA.o_StallD, ifA.o_FlushE}), 32'b111);
        runCycle(z);
        checkOutput("lw_cnt", 32'(ifA.o_stallcnt), 32'd1);

        s = z; s.branchD = 1; s.rsD = 7; s.rwE = 1; s.wE = 7;
        runCycle(s);
        checkOutput("br_stall", 32'(ifA.o_StallF), 32'd1);
        s = z; s.branchD = 1; s.rsD = 7; s.rwM = 1; s.wM = 7;
        runCycle(s);
        checkOutput("br_fwdAD", 32'({ifA.o_ForwardAD, ifA.o_StallF}), 32'b10);

        base = stallCount[0];
        s = z; s.mdstartE = 1;
        runCycle(s);
        runCycle(z);
        runCycle(z);
        runCycle(z);
        checkOutput("md_busy_last", 32'({ifA.o_mdbusy, ifA.o_StallF}), 32'b10);
        runCycle(z);
        checkOutput("md_run", 32'(ifA.o_mdbusy), 32'd0);
        checkOutput("md_cnt", 32'(ifA.o_stallcnt), 32'(base + 3));

        doReset();
        for (int i = 0; i < 5; i++) begin
            s = z; s.memreqM = 1; s.ready = 0; s.mdstartE = (i == 0);
            runCycle(s);
            checkOutput("mem_hold", 32'({ifB.o_StallM, ifB.o_FlushW}), 32'b11);
        end
        checkOutput("mem_mdwait", 32'(ifB.o_mdbusy), 32'd1);
        s = z; s.memreqM = 1; s.ready = 1;
        runCycle(s);
        runCycle(z);
        checkOutput("mem_run", 32'(ifB.o_mdbusy), 32'd0);

        s = z; s.mdstartE = 1;
        runCycle(s);
        runCycle(z);
        doReset();
        runCycle(z);
        checkOutput("rst_run", 32'(ifA.o_mdbusy), 32'd0);

        s = z; s.mtrE = 1; s.wE = 2; s.rsD = 2;
        for (int i = 0; i < 6; i++)
            runCycle(s);
        runCycle(z);
        checkOutput("sat_B", 32'(ifB.o_stallcnt), 32'd3);
        checkOutput("sat_A", 32'(ifA.o_stallcnt), 32'd6);

        for (int i = 0; i < 3000; i++) begin
            runCycle(randStim());
            if ($urandom_range(0, 299) == 0)
                doReset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard, forwarding and stall controller for the 5-stage MIPS pipeline (F/D/E/M/W). It extends the existing hazard logic with three additions:
- a memory-ready handshake that freezes the whole pipeline while data memory is busy;
- a multi-cycle execute unit (mul/div) tracked by an internal FSM and counter;
- a saturating stall-cycle counter for performance checks.

It drives the stage-register enables and clears, and the forwarding mux selects, of the datapath.

## Interface
Parameters:
- RW, 5: register-address width
- MD_LAT, 4: total E-stage occupancy of a multi-cycle op, in cycles; legal range 1..15
- CW, 16: stall-counter width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- rsD, rtD, rsE, rtE  in  RW each  source registers in D and E
- writeregE, writeregM, writeregW  in  RW each  destination registers
- regwriteE, regwriteM, regwriteW  in  1 each  register-write enables
- memtoregE, memtoregM  in  1 each  load in E / in M
- branchD  in  1  branch compare in D
- mdstartE  in  1  multi-cycle op occupies E
- memreqM  in  1  M performs a data-memory access
- ready  in  1  data memory ready
- StallF, StallD, StallE, StallM  out  1 each  hold stage register
- FlushE, FlushM, FlushW  out  1 each  insert bubble into stage register
- ForwardAD, ForwardBD  out  1 each  select aluoutM for the D compare
- ForwardAE, ForwardBE  out  2 each  E source select: 00 regfile, 01 resultW, 10 aluoutM
- mdbusy  out  1  FSM in MDWAIT
- stallcnt  out  CW  saturating count of cycles with StallF=1

## Operation
- Register 0 never matches; every compare below also requires a nonzero address.
- Forwarding, evaluated combinationally every cycle, M priority over W:
  - ForwardAE = 10 if regwriteM and writeregM==rsE; else 01 if regwriteW and writeregW==rsE; else 00.
  - ForwardBE uses the same rule with rtE.
  - ForwardAD = regwriteM and writeregM==rsD; ForwardBD uses the same rule with rtD.
- Stall sources:
  - lwstall = memtoregE and (writeregE==rsD or writeregE==rtD).
  - brstall = branchD and ((regwriteE and writeregE matches rsD/rtD) or (memtoregM and writeregM matches rsD/rtD)).
  - memstall = memreqM and not ready.
  - mdstall is defined by the FSM below.
- Priority: memstall > mdstall > (lwstall or brstall).
  - memstall: StallF=StallD=StallE=StallM=1, FlushW=1, all other flushes 0.
  - else mdstall: StallF=StallD=StallE=1, FlushM=1.
  - else lwstall or brstall: StallF=StallD=1, FlushE=1.
  - else all stall and flush outputs 0.
- FSM states: RUN, MDWAIT. Counter cnt is 4 bits.
  - RUN with mdstartE and MD_LAT>1: mdstall=1, cnt<=MD_LAT-2, go to MDWAIT.
  - RUN with MD_LAT==1: mdstall=0 and the state stays RUN.
  - MDWAIT with cnt!=0: mdstall=1, cnt<=cnt-1.
  - MDWAIT with cnt==0: mdstall=0. Go to RUN if not memstall; otherwise hold MDWAIT with cnt at 0.
  - The counter keeps decrementing during memstall because the multi-cycle unit runs independently.
  - mdstartE is ignored in MDWAIT.
  - mdbusy = (state==MDWAIT).
- stallcnt increments by 1 on every clock edge where StallF=1 and saturates at 2^CW-1.

## Timing
- Reset (reset low) asynchronously forces state=RUN, cnt=0, stallcnt=0.
- All other outputs are combinational. With all inputs at 0 every output is 0.
- Reset asserted mid-MDWAIT aborts the op; the FSM is in RUN on the first cycle after reset release.
- A multi-cycle op occupies E for exactly MD_LAT cycles without memstall; mdstall is high for the first MD_LAT-1 of them.
- The ready handshake is level-based. The pipeline advances on the first edge where ready=1 (or memreqM=0).
- No added latency: a stall is visible in the same cycle as the hazard.

## Test plan
- Forwarding:
  - rsE=3, writeregM=3, regwriteM=1 and writeregW=3, regwriteW=1 -> ForwardAE=10.
  - Drop regwriteM -> ForwardAE=01.
  - rsE=0 in either case -> ForwardAE=00.
- Load-use: memtoregE=1, regwriteE=1, writeregE=5, rtD=5 -> StallF=StallD=FlushE=1 for one cycle; stallcnt goes 0->1.
- Branch hazard: branchD=1, rsD=7, regwriteE=1, writeregE=7 -> brstall asserted. Next cycle with the instruction moved to M as an ALU op: ForwardAD=1 and no stall.
- Multi-cycle, MD_LAT=4: mdstartE=1 in RUN -> mdstall for 3 cycles with FlushM=1 and mdbusy=1 for 3 cycles, then back to RUN; stallcnt=3.
- Memory wait overlapping multi-cycle: memreqM=1, ready=0 for 5 cycles starting at mdstartE with MD_LAT=3 -> StallM=1 and FlushW=1 for 5 cycles; FSM holds MDWAIT at cnt=0 until ready=1, then returns to RUN.
- Reset and saturation:
  - reset low during MDWAIT -> state=RUN and stallcnt=0 immediately.
  - CW=2 with 6 stall cycles -> stallcnt=3.
